// File: rtl/sd_spi_card_responder_if.sv
// SD SPI link bundle: card pins plus the sector-buffer/read-request handshake.
// The card end uses the slave modport; the host/buffer side uses master.
interface sd_spi_card_responder_if;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic        spi_miso;
  logic        rd_req;
  logic [31:0] rd_lba;
  logic        rd_ack;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_data;

  modport slave (
    input  spi_sck, spi_mosi, spi_cs_n, rd_ack, buf_data,
    output spi_miso, rd_req, rd_lba, buf_addr
  );

  modport master (
    output spi_sck, spi_mosi, spi_cs_n, rd_ack, buf_data,
    input  spi_miso, rd_req, rd_lba, buf_addr
  );
endinterface

// File: rtl/sd_spi_card_responder.sv
// SPI-mode SD card target: oversamples the SPI pins in the clk8 domain, decodes
// command frames, answers R1/R3/R7 and streams one 512-byte sector for CMD17.
module sd_spi_card_responder #(
  parameter logic [31:0] OCR_VALUE   = 32'hC0FF8000,
  parameter int          NCR_BYTES   = 1,
  parameter int          ACMD41_BUSY = 1
) (
  input  logic                          clk8,
  input  logic                          reset,
  sd_spi_card_responder_if.slave        sd,
  output logic                          idle_o
);
  typedef enum logic [2:0] {
    ST_RX, ST_NCR, ST_RESP, ST_RDWAIT, ST_TOKEN, ST_DATA, ST_CRC
  } state_t;

  localparam logic [2:0] NCR_LAST     = 3'(NCR_BYTES - 1);
  localparam logic [7:0] ACMD41_LIMIT = 8'(ACMD41_BUSY);

  logic [2:0]  sck_q;
  logic [1:0]  mosi_q;
  logic [1:0]  cs_q;
  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_shift_q;
  logic [7:0]  tx_shift_q;
  logic [7:0]  tx_byte_q;
  logic        use_buf_q;
  logic [2:0]  frame_cnt_q;
  logic [5:0]  cmd_q;
  logic [31:0] arg_q;
  logic [7:0]  r1_q;
  logic [31:0] resp_q;
  logic [2:0]  resp_cnt_q;
  logic        read_q;
  logic [2:0]  ncr_cnt_q;
  logic        crc_cnt_q;
  logic        ack_seen_q;
  logic        idle_q;
  logic        app_cmd_q;
  logic [7:0]  acmd_cnt_q;
  logic        miso_q;
  logic        rd_req_q;
  logic [31:0] rd_lba_q;
  logic [8:0]  buf_addr_q;

  logic        sck_rise, sck_fall, cs_active;
  logic [7:0]  rx_byte_d;

  // sck_q[1] is the synchronised level, sck_q[2] its previous value.
  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign cs_active = ~cs_q[1];
  assign rx_byte_d = {rx_shift_q, mosi_q[1]};

  assign sd.spi_miso = miso_q;
  assign sd.rd_req   = rd_req_q;
  assign sd.rd_lba   = rd_lba_q;
  assign sd.buf_addr = buf_addr_q;
  assign idle_o      = idle_q;

  logic [7:0]  r1_d;
  logic [31:0] extra_d;
  logic        has_extra_d, read_d, idle_d, app_cmd_d;
  logic [7:0]  acmd_cnt_d;

  // Command decode, evaluated against the completed frame held in cmd_q/arg_q.
  always_comb begin
    r1_d        = {7'b0, idle_q};
    extra_d     = 32'hFFFF_FFFF;
    has_extra_d = 1'b0;
    read_d      = 1'b0;
    idle_d      = idle_q;
    app_cmd_d   = 1'b0;
    acmd_cnt_d  = acmd_cnt_q;
    case (cmd_q)
      6'd0: begin
        idle_d     = 1'b1;
        acmd_cnt_d = 8'd0;
        r1_d       = 8'h01;
      end
      6'd8: begin
        has_extra_d = 1'b1;
        extra_d     = {16'h0000, 4'h0, arg_q[11:8], arg_q[7:0]};
      end
      6'd16: r1_d = {7'b0, idle_q};
      6'd55: app_cmd_d = 1'b1;
      6'd41: begin
        if (!app_cmd_q) begin
          r1_d = {7'b0, idle_q} | 8'h04;
        end else if (acmd_cnt_q < ACMD41_LIMIT) begin
          r1_d       = 8'h01;
          acmd_cnt_d = acmd_cnt_q + 8'd1;
        end else begin
          idle_d = 1'b0;
          r1_d   = 8'h00;
        end
      end
      6'd58: begin
        has_extra_d = 1'b1;
        extra_d     = OCR_VALUE;
      end
      6'd17: begin
        if (idle_q) begin
          r1_d = 8'h05;
        end else begin
          r1_d   = 8'h00;
          read_d = 1'b1;
        end
      end
      default: r1_d = {7'b0, idle_q} | 8'h04;
    endcase
  end

  always_ff @(posedge clk8) begin
    if (reset) begin
      sck_q       <= 3'b000;
      mosi_q      <= 2'b11;
      cs_q        <= 2'b11;
      state_q     <= ST_RX;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'h7F;
      tx_shift_q  <= 8'hFF;
      tx_byte_q   <= 8'hFF;
      use_buf_q   <= 1'b0;
      frame_cnt_q <= 3'd0;
      cmd_q       <= 6'd0;
      arg_q       <= 32'd0;
      r1_q        <= 8'hFF;
      resp_q      <= 32'hFFFF_FFFF;
      resp_cnt_q  <= 3'd0;
      read_q      <= 1'b0;
      ncr_cnt_q   <= 3'd0;
      crc_cnt_q   <= 1'b0;
      ack_seen_q  <= 1'b0;
      idle_q      <= 1'b1;
      app_cmd_q   <= 1'b0;
      acmd_cnt_q  <= 8'd0;
      miso_q      <= 1'b1;
      rd_req_q    <= 1'b0;
      rd_lba_q    <= 32'd0;
      buf_addr_q  <= 9'd0;
    end else begin
      sck_q    <= {sck_q[1:0], sd.spi_sck};
      mosi_q   <= {mosi_q[0], sd.spi_mosi};
      cs_q     <= {cs_q[0], sd.spi_cs_n};
      rd_req_q <= 1'b0;
      if (state_q == ST_RDWAIT && sd.rd_ack) ack_seen_q <= 1'b1;

      if (!cs_active) begin
        bit_cnt_q   <= 3'd0;
        miso_q      <= 1'b1;
        state_q     <= ST_RX;
        frame_cnt_q <= 3'd0;
        tx_shift_q  <= 8'hFF;
        tx_byte_q   <= 8'hFF;
        use_buf_q   <= 1'b0;
        ack_seen_q  <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_shift_q <= rx_byte_d[6:0];
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Byte boundary: choose what the next byte on MISO will be.
            tx_byte_q <= 8'hFF;
            use_buf_q <= 1'b0;
            case (state_q)
              ST_RX: begin
                if (frame_cnt_q == 3'd0) begin
                  if (rx_byte_d[7:6] == 2'b01) begin
                    cmd_q       <= rx_byte_d[5:0];
                    frame_cnt_q <= 3'd1;
                  end
                end else if (frame_cnt_q == 3'd5) begin
                  frame_cnt_q <= 3'd0;
                  state_q     <= ST_NCR;
                  ncr_cnt_q   <= 3'd0;
                  r1_q        <= r1_d;
                  resp_q      <= extra_d;
                  resp_cnt_q  <= has_extra_d ? 3'd4 : 3'd0;
                  read_q      <= read_d;
                  idle_q      <= idle_d;
                  app_cmd_q   <= app_cmd_d;
                  acmd_cnt_q  <= acmd_cnt_d;
                end else begin
                  arg_q       <= {arg_q[23:0], rx_byte_d};
                  frame_cnt_q <= frame_cnt_q + 3'd1;
                end
              end
              ST_NCR: begin
                if (ncr_cnt_q == NCR_LAST) begin
                  state_q   <= ST_RESP;
                  tx_byte_q <= r1_q;
                end else begin
                  ncr_cnt_q <= ncr_cnt_q + 3'd1;
                end
              end
              ST_RESP: begin
                if (resp_cnt_q != 3'd0) begin
                  tx_byte_q  <= resp_q[31:24];
                  resp_q     <= {resp_q[23:0], 8'hFF};
                  resp_cnt_q <= resp_cnt_q - 3'd1;
                end else if (read_q) begin
                  state_q    <= ST_RDWAIT;
                  rd_req_q   <= 1'b1;
                  rd_lba_q   <= arg_q;
                  ack_seen_q <= 1'b0;
                end else begin
                  state_q <= ST_RX;
                end
              end
              ST_RDWAIT: begin
                if (ack_seen_q || sd.rd_ack) begin
                  state_q    <= ST_TOKEN;
                  tx_byte_q  <= 8'hFE;
                  ack_seen_q <= 1'b0;
                end
              end
              ST_TOKEN: begin
                // Address is presented a full half-SCK before the falling edge reads buf_data.
                state_q    <= ST_DATA;
                buf_addr_q <= 9'd0;
                use_buf_q  <= 1'b1;
              end
              ST_DATA: begin
                if (buf_addr_q == 9'd511) begin
                  state_q   <= ST_CRC;
                  crc_cnt_q <= 1'b0;
                end else begin
                  buf_addr_q <= buf_addr_q + 9'd1;
                  use_buf_q  <= 1'b1;
                end
              end
              ST_CRC: begin
                if (crc_cnt_q) state_q <= ST_RX;
                else           crc_cnt_q <= 1'b1;
              end
              default: state_q <= ST_RX;
            endcase
          end
        end

        if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            if (use_buf_q) begin
              miso_q     <= sd.buf_data[7];
              tx_shift_q <= {sd.buf_data[6:0], 1'b1};
            end else begin
              miso_q     <= tx_byte_q[7];
              tx_shift_q <= {tx_byte_q[6:0], 1'b1};
            end
          end else begin
            miso_q     <= tx_shift_q[7];
            tx_shift_q <= {tx_shift_q[6:0], 1'b1};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Bench for sd_spi_card_responder: host-side SPI driver, sector buffer and rd_ack
// model, with expected MISO bytes queued per transaction and compared as they arrive.
module tb_sd_spi_card_responder;
  localparam int HALF = 4;

  logic clk8 = 1'b0;
  logic reset;
  logic idle_o;

  sd_spi_card_responder_if sd ();

  sd_spi_card_responder dut (
    .clk8   (clk8),
    .reset  (reset),
    .sd     (sd),
    .idle_o (idle_o)
  );

  always #5 clk8 = ~clk8;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int req_cnt = 0;
  int ack_timer = 0;
  int ack_delay = 40;

  // Sector buffer holds buf[i] = i[7:0] with one cycle of read latency.
  always @(posedge clk8) sd.buf_data <= sd.buf_addr[7:0];

  always @(posedge clk8) begin
    sd.rd_ack <= 1'b0;
    if (sd.rd_req) begin
      req_cnt   <= req_cnt + 1;
      ack_timer <= ack_delay;
    end else if (ack_timer > 0) begin
      ack_timer <= ack_timer - 1;
      if (ack_timer == 1) sd.rd_ack <= 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk8);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sd.spi_mosi = b;
    tick(HALF);
    r = sd.spi_miso;
    sd.spi_sck = 1'b1;
    tick(HALF);
    sd.spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic send_frame(input logic [5:0] cmd, input logic [31:0] arg);
    logic [7:0] fr [6];
    logic [7:0] rx;
    fr[0] = {2'b01, cmd};
    fr[1] = arg[31:24];
    fr[2] = arg[23:16];
    fr[3] = arg[15:8];
    fr[4] = arg[7:0];
    fr[5] = (cmd == 6'd0) ? 8'h95 : 8'h01;
    for (int i = 0; i < 6; i++) spi_byte(fr[i], rx);
  endtask

  task automatic recv(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      spi_byte(8'hFF, b);
      got_q.push_back(b);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    sd.spi_cs_n = 1'b1;
    sd.spi_sck  = 1'b0;
    sd.spi_mosi = 1'b1;
    tick(4);
    n_cmp++; if (sd.spi_miso !== 1'b1) begin n_err++; $display("FAIL reset_miso: got %b expected 1", sd.spi_miso); end
    n_cmp++; if (sd.rd_req !== 1'b0) begin n_err++; $display("FAIL reset_rd_req: got %b expected 0", sd.rd_req); end
    n_cmp++; if (sd.rd_lba !== 32'd0) begin n_err++; $display("FAIL reset_rd_lba: got %08h expected 00000000", sd.rd_lba); end
    n_cmp++; if (sd.buf_addr !== 9'd0) begin n_err++; $display("FAIL reset_buf_addr: got %0d expected 0", sd.buf_addr); end
    n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", idle_o); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_cmd0;
    logic [7:0] e, g, junk;
    sd.spi_cs_n = 1'b0;
    tick(4);
    spi_byte(8'h12, junk);  // non-frame byte between frames is ignored
    got_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    send_frame(6'd0, 32'd0);
    recv(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL cmd0_resp: got %02h expected %02h", g, e); end
    end
    n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL cmd0_idle: got %b expected 1", idle_o); end
    $display("cmd0 done: idle_o=%b", idle_o);
  endtask

  task automatic test_idle_cmds;
    logic [7:0] e, g;
    int base;
    base = req_cnt;
    got_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h05);  // CMD17 while idle
    send_frame(6'd17, 32'h0000_0042); recv(2);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h05);  // CMD63 illegal
    send_frame(6'd63, 32'd0); recv(2);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h05);  // CMD41 without CMD55
    send_frame(6'd41, 32'h4000_0000); recv(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL idle_cmds_resp: got %02h expected %02h", g, e); end
    end
    n_cmp++; if (req_cnt - base !== 0) begin n_err++; $display("FAIL idle_cmd17_no_req: got %0d rd_req expected 0", req_cnt - base); end
    $display("idle commands done");
  endtask

  task automatic test_init;
    logic [7:0] e, g;
    logic [7:0] r7 [6];
    r7[0] = 8'hFF; r7[1] = 8'h01; r7[2] = 8'h00; r7[3] = 8'h00; r7[4] = 8'h01; r7[5] = 8'hAA;
    got_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(r7[i]);
    send_frame(6'd8, 32'h0000_01AA); recv(6);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    send_frame(6'd55, 32'd0); recv(2);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    send_frame(6'd41, 32'h4000_0000); recv(2);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    send_frame(6'd55, 32'd0); recv(2);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send_frame(6'd41, 32'h4000_0000); recv(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL init_resp: got %02h expected %02h", g, e); end
    end
    n_cmp++; if (idle_o !== 1'b0) begin n_err++; $display("FAIL init_idle: got %b expected 0", idle_o); end
    $display("init done: idle_o=%b", idle_o);
  endtask

  task automatic test_cmd58;
    logic [7:0] e, g;
    logic [7:0] r3 [6];
    r3[0] = 8'hFF; r3[1] = 8'h00; r3[2] = 8'hC0; r3[3] = 8'hFF; r3[4] = 8'h80; r3[5] = 8'h00;
    got_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(r3[i]);
    send_frame(6'd58, 32'd0); recv(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL cmd58_resp: got %02h expected %02h", g, e); end
    end
    $display("cmd58 done");
  endtask

  task automatic test_read;
    logic [7:0] e, g, b;
    int base, ff_cnt;
    bit found;
    base = req_cnt;
    ack_delay = 40;
    got_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send_frame(6'd17, 32'h0000_1234); recv(2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL read_r1: got %02h expected %02h", g, e); end
    end
    ff_cnt = 0; found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      spi_byte(8'hFF, b);
      if (b === 8'hFE) found = 1'b1;
      else begin
        ff_cnt++;
        n_cmp++; if (b !== 8'hFF) begin n_err++; $display("FAIL read_wait_byte: got %02h expected FF", b); end
      end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL read_token: got no FE within 64 bytes expected FE"); end
    n_cmp++; if (ff_cnt < 1) begin n_err++; $display("FAIL read_wait_ff: got %0d FF bytes expected >=1", ff_cnt); end
    n_cmp++; if (sd.rd_lba !== 32'h0000_1234) begin n_err++; $display("FAIL read_lba: got %08h expected 00001234", sd.rd_lba); end
    if (found) begin
      got_q.delete();
      for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
      recv(514);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        n_cmp++; if (g !== e) begin n_err++; $display("FAIL read_data: got %02h expected %02h", g, e); end
      end
    end
    n_cmp++; if (req_cnt - base !== 1) begin n_err++; $display("FAIL read_req_once: got %0d rd_req expected 1", req_cnt - base); end
    $display("read done: wait_ff=%0d lba=%08h", ff_cnt, sd.rd_lba);
  endtask

  task automatic test_cs_abort;
    logic [7:0] e, g, b;
    logic r;
    bit found;
    ack_delay = 40;
    got_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send_frame(6'd17, 32'h0000_0055); recv(2);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      spi_byte(8'hFF, b);
      if (b === 8'hFE) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL abort_token: got no FE within 64 bytes expected FE"); end
    for (int i = 0; i < 100; i++) exp_q.push_back(8'(i));
    recv(100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL abort_pre_data: got %02h expected %02h", g, e); end
    end
    for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
    sd.spi_cs_n = 1'b1;
    tick(8);
    n_cmp++; if (sd.spi_miso !== 1'b1) begin n_err++; $display("FAIL abort_miso: got %b expected 1", sd.spi_miso); end
    sd.spi_cs_n = 1'b0;
    tick(4);
    got_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hC0);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h80); exp_q.push_back(8'h00);
    send_frame(6'd58, 32'd0); recv(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL abort_cmd58: got %02h expected %02h", g, e); end
    end
    $display("cs abort done");
  endtask

  task automatic test_reset_rdwait;
    logic [7:0] e, g;
    int base;
    base = req_cnt;
    ack_delay = 250;  // ack lands after the reset, so it must be ignored
    got_q.delete();
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    send_frame(6'd17, 32'h0000_0077); recv(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL rst_rdwait_pre: got %02h expected %02h", g, e); end
    end
    reset = 1'b1;
    tick(2);
    n_cmp++; if (sd.spi_miso !== 1'b1) begin n_err++; $display("FAIL rst_rdwait_miso: got %b expected 1", sd.spi_miso); end
    n_cmp++; if (idle_o !== 1'b1) begin n_err++; $display("FAIL rst_rdwait_idle: got %b expected 1", idle_o); end
    n_cmp++; if (sd.rd_lba !== 32'd0) begin n_err++; $display("FAIL rst_rdwait_lba: got %08h expected 00000000", sd.rd_lba); end
    reset = 1'b0;
    tick(4);
    got_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'hFF);
    recv(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL rst_rdwait_post: got %02h expected %02h", g, e); end
    end
    n_cmp++; if (req_cnt - base !== 1) begin n_err++; $display("FAIL rst_rdwait_req: got %0d rd_req expected 1", req_cnt - base); end
    n_cmp++; if (sd.buf_addr !== 9'd0) begin n_err++; $display("FAIL rst_rdwait_buf_addr: got %0d expected 0", sd.buf_addr); end
    sd.spi_cs_n = 1'b1;
    $display("reset mid-rdwait done");
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_idle_cmds();
    test_init();
    test_cmd58();
    test_read();
    test_cs_abort();
    test_reset_rdwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached before the bench completed");
    $fatal(1, "watchdog");
  end
endmodule
